// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller.
// Reads upper/lower half pixels from a frame buffer, shifts one bit plane per row
// out on sclk, latches it, then lights the panel for a binary-weighted OE time.
// Optional build macro: HUB75_GAMMA_EN maps each 4-bit channel through a gamma table.
module hub75_scan_ctrl #(
  parameter int WIDTH     = 128,
  parameter int HEIGHT    = 32,
  parameter int CHAINED   = 1,
  parameter int BPP       = 12,
  parameter int BPC       = 4,
  parameter int CLK_DIV   = 8,
  parameter int BASE_TIME = 16
) (
  input  logic            clk,
  input  logic            RESET,
  input  logic            enable,
  output logic [13:0]     mem_addr,
  output logic            mem_re,
  output logic            mem_we,
  input  logic [BPP-1:0]  mem_data,
  output logic            sclk,
  output logic            lat,
  output logic            oe,
  output logic            a,
  output logic            b,
  output logic            c,
  output logic            d,
  output logic            r0,
  output logic            g0,
  output logic            b0,
  output logic            r1,
  output logic            g1,
  output logic            b1,
  output logic            frame_done
);

  localparam int W_T      = WIDTH * CHAINED;
  localparam int ROWS     = HEIGHT / 2;
  localparam int ADDR_W   = 14;
  localparam int COL_W    = (W_T > 1) ? $clog2(W_T) : 1;
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PLANE_W  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int MAX_DISP = BASE_TIME << (BPC - 1);
  localparam int CNT_W    = $clog2(MAX_DISP + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t               r_state, w_state;
  logic [DIV_W-1:0]     r_div, w_div;
  logic [COL_W-1:0]     r_col, w_col;
  logic [ROW_W-1:0]     r_row, w_row;
  logic [PLANE_W-1:0]   r_plane, w_plane;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [BPP-1:0]       r_upper, w_upper;
  logic [ADDR_W-1:0]    r_addr, w_addr;
  logic                 r_re, w_re;
  logic                 r_sclk, w_sclk;
  logic                 r_lat, w_lat;
  logic                 r_oe, w_oe;
  logic [3:0]           r_abcd, w_abcd;
  logic [5:0]           r_rgb, w_rgb;
  logic                 r_done, w_done;
  logic [CNT_W-1:0]     w_disp_last;

  // Frame-buffer address of a pixel; half selects the lower panel half.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                 input logic half,
                                                 input logic [COL_W-1:0] col);
    int r;
    r = int'(row) + (half ? ROWS : 0);
    return ADDR_W'(r * W_T + int'(col));
  endfunction

`ifdef HUB75_GAMMA_EN
  // Perceptual gamma curve for 4-bit channels.
  function automatic logic [3:0] gamma4(input logic [3:0] v);
    logic [3:0] g;
    case (v)
      4'd0, 4'd1, 4'd2: g = 4'd0;
      4'd3, 4'd4, 4'd5: g = 4'd1;
      4'd6, 4'd7:       g = 4'd2;
      4'd8:             g = 4'd3;
      4'd9:             g = 4'd4;
      4'd10:            g = 4'd5;
      4'd11:            g = 4'd6;
      4'd12:            g = 4'd8;
      4'd13:            g = 4'd10;
      4'd14:            g = 4'd12;
      default:          g = 4'd15;
    endcase
    return g;
  endfunction
`endif

  // One bit plane of a colour channel.
  function automatic logic chan_bit(input logic [BPC-1:0] ch, input logic [PLANE_W-1:0] pl);
    logic [BPC-1:0] v;
`ifdef HUB75_GAMMA_EN
    v = BPC'(gamma4(4'(ch)));
`else
    v = ch;
`endif
    return v[pl];
  endfunction

  assign w_disp_last = (CNT_W'(BASE_TIME) << r_plane) - CNT_W'(1);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_col   = r_col;
    w_row   = r_row;
    w_plane = r_plane;
    w_cnt   = r_cnt;
    w_upper = r_upper;
    w_addr  = r_addr;
    w_re    = r_re;
    w_sclk  = r_sclk;
    w_lat   = r_lat;
    w_oe    = r_oe;
    w_abcd  = r_abcd;
    w_rgb   = r_rgb;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_oe   = 1'b1;
        w_sclk = 1'b0;
        w_lat  = 1'b0;
        w_re   = 1'b0;
        if (enable) begin
          w_state = S_SHIFT;
          w_div   = '0;
          w_col   = '0;
          w_addr  = pix_addr(r_row, 1'b0, COL_W'(0));
          w_re    = 1'b1;
        end
      end
      S_SHIFT: begin
        w_div = r_div + DIV_W'(1);
        if (r_div == DIV_W'(0)) begin
          w_addr = pix_addr(r_row, 1'b1, r_col);
          w_re   = 1'b1;
        end
        if (r_div == DIV_W'(1)) begin
          w_re    = 1'b0;
          w_upper = mem_data;
        end
        if (r_div == DIV_W'(2)) begin
          w_rgb = {chan_bit(r_upper[3*BPC-1 -: BPC], r_plane),
                   chan_bit(r_upper[2*BPC-1 -: BPC], r_plane),
                   chan_bit(r_upper[BPC-1 -: BPC],   r_plane),
                   chan_bit(mem_data[3*BPC-1 -: BPC], r_plane),
                   chan_bit(mem_data[2*BPC-1 -: BPC], r_plane),
                   chan_bit(mem_data[BPC-1 -: BPC],   r_plane)};
        end
        // sclk rises one clk after the colour bits settle.
        if (r_div == DIV_W'(CLK_DIV / 2)) begin
          w_sclk = 1'b1;
        end
        if (r_div == DIV_W'(CLK_DIV - 1)) begin
          w_sclk = 1'b0;
          w_div  = '0;
          if (r_col == COL_W'(W_T - 1)) begin
            w_state = S_LATCH;
            w_lat   = 1'b1;
            w_abcd  = 4'(r_row);
            w_cnt   = '0;
          end else begin
            w_col  = r_col + COL_W'(1);
            w_addr = pix_addr(r_row, 1'b0, r_col + COL_W'(1));
            w_re   = 1'b1;
          end
        end
      end
      S_LATCH: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state = S_DISPLAY;
          w_lat   = 1'b0;
          w_oe    = 1'b0;
          w_cnt   = '0;
        end
      end
      S_DISPLAY: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (r_cnt == w_disp_last) begin
          w_oe  = 1'b1;
          w_cnt = '0;
          if (r_plane == PLANE_W'(BPC - 1)) begin
            w_plane = '0;
            if (r_row == ROW_W'(ROWS - 1)) begin
              w_row  = '0;
              w_done = 1'b1;
            end else begin
              w_row = r_row + ROW_W'(1);
            end
          end else begin
            w_plane = r_plane + PLANE_W'(1);
          end
          // enable is only sampled here, so a plane is never cut short.
          if (enable) begin
            w_state = S_SHIFT;
            w_div   = '0;
            w_col   = '0;
            w_addr  = pix_addr(w_row, 1'b0, COL_W'(0));
            w_re    = 1'b1;
          end else begin
            w_state = S_IDLE;
          end
        end
      end
    endcase
  end

  // State and output registers; reset blanks the panel without waiting for clk.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_plane <= '0;
      r_cnt   <= '0;
      r_upper <= '0;
      r_addr  <= '0;
      r_re    <= 1'b0;
      r_sclk  <= 1'b0;
      r_lat   <= 1'b0;
      r_oe    <= 1'b1;
      r_abcd  <= '0;
      r_rgb   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_col   <= w_col;
      r_row   <= w_row;
      r_plane <= w_plane;
      r_cnt   <= w_cnt;
      r_upper <= w_upper;
      r_addr  <= w_addr;
      r_re    <= w_re;
      r_sclk  <= w_sclk;
      r_lat   <= w_lat;
      r_oe    <= w_oe;
      r_abcd  <= w_abcd;
      r_rgb   <= w_rgb;
      r_done  <= w_done;
    end
  end

  assign mem_addr   = r_addr;
  assign mem_re     = r_re;
  assign mem_we     = 1'b0;
  assign sclk       = r_sclk;
  assign lat        = r_lat;
  assign oe         = r_oe;
  assign {d, c, b, a} = r_abcd;
  assign {r0, g0, b0, r1, g1, b1} = r_rgb;
  assign frame_done = r_done;

endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter WIDTH, 128, columns per panel.
REQ-002 Parameter HEIGHT, 32, panel rows; scan rows = HEIGHT/2, addressed by a..d.
REQ-003 Parameter CHAINED, 1, panels in chain; W_T = WIDTH*CHAINED.
REQ-004 Parameter BPP, 12, pixel word {R,G,B}; BPC, 4, bits per channel.
REQ-005 Parameter CLK_DIV, 8, clk cycles per sclk period; even, >= 6.
REQ-006 Parameter BASE_TIME, 16, OE-on clk cycles for bit plane 0.
REQ-007 clk input 1: system clock.
REQ-008 RESET input 1: reset, asynchronous, active-high.
REQ-009 enable input 1: scan run request.
REQ-010 mem_addr output 14: read address into frame-buffer read port.
REQ-011 mem_re output 1: read strobe; mem_we output 1: tied 0.
REQ-012 mem_data input BPP: read data, valid 1 clk after mem_re.
REQ-013 sclk, lat, oe, a, b, c, d output 1 each: HUB75 control; oe active-low.
REQ-014 r0, g0, b0, r1, g1, b1 output 1 each: upper-half / lower-half colour bits.
REQ-015 frame_done output 1: one-clk pulse at end of each full frame.

Function
REQ-016 FSM states IDLE, SHIFT, LATCH, DISPLAY; all registered outputs.
REQ-017 IDLE -> SHIFT when enable=1; row=0, plane=0.
REQ-018 SHIFT: per column slot of CLK_DIV clks, col 0 first, cols 0..W_T-1; oe=1 throughout.
REQ-019 Slot clk 0: mem_addr=row*W_T+col, mem_re=1; clk 1: mem_addr=(row+HEIGHT/2)*W_T+col, mem_re=1, capture upper pixel.
REQ-020 Slot clk 2: capture lower pixel; drive r0/g0/b0 and r1/g1/b1 with bit [plane] of each channel; sclk=0.
REQ-021 Slot clk CLK_DIV/2: sclk=1 (data stable >= 1 clk before rise); slot end: sclk=0; mem_re=0 outside clks 0-1.
REQ-022 After col W_T-1 -> LATCH: a..d=row, lat=1 for 2 clks, then lat=0 -> DISPLAY.
REQ-023 DISPLAY: oe=0 for exactly BASE_TIME<<plane clks, then oe=1.
REQ-024 End of DISPLAY: plane+1; at plane=BPC-1 wrap plane=0, row+1; at row=HEIGHT/2-1 wrap row=0, frame_done=1 for one clk.
REQ-025 After DISPLAY: enable=1 -> SHIFT; enable=0 -> IDLE. enable drop during SHIFT/LATCH/DISPLAY takes effect only at end of DISPLAY.
REQ-026 In IDLE: oe=1, sclk=0, lat=0, mem_re=0; row/plane retained; re-enable resumes at next plane.
REQ-027 Row and plane counters sized for HEIGHT/2 and BPC; column counter for W_T; no overflow beyond wrap points.

Reset
REQ-028 RESET=1 immediately forces IDLE: sclk=0, lat=0, oe=1, a..d=0, rgb outputs=0, mem_addr=0, mem_re=0, mem_we=0, frame_done=0, row=plane=col=0.
REQ-029 Reset mid-DISPLAY blanks panel (oe=1) asynchronously, without waiting for clk.

Configuration
REQ-030 Macro HUB75_GAMMA_EN defined: each captured BPC=4 channel mapped through table 0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15 before bit extraction; adds no latency.
REQ-031 Macro undefined: raw channel bits used; no table logic synthesised.

Verification (WIDTH=4, HEIGHT=4, CHAINED=1, CLK_DIV=6, BASE_TIME=2)
REQ-032 Assert RESET mid-run -> same edge oe=1, sclk=lat=mem_re=0, a..d=0.
REQ-033 enable=1 -> mem_addr order 0,8,1,9,2,10,3,11 for row 0; mem addr0=12'hF00 -> r0=1, g0=b0=0 on 1st sclk rise of all 4 planes.
REQ-034 Measure oe low per plane on row 0 -> 2, 4, 8, 16 clks; lat high 2 clks before each; 4 sclk rises per SHIFT.
REQ-035 Run full frame -> a..d=0 then 1, wrap to 0 after row 1 plane 3; frame_done single-clk pulse exactly once.
REQ-036 enable=0 during SHIFT -> current LATCH and DISPLAY complete, then IDLE with oe=1; enable=1 -> resumes at next plane.
REQ-037 Pixel R=4'h8: with HUB75_GAMMA_EN r0=1 in planes 0,1 only; without, r0=1 in plane 3 only.
